// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings,
// port indices and a small helper that turns a port index into a grant.
package dm_arbiter_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam int PORT_CPU = 0;
   localparam int PORT_LDR = 1;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational two-way picker for the data-memory arbiter. Produces a
// one-hot winner from the request vector using either fixed CPU priority
// with a starvation override, or round-robin against the last served port.
module dm_arb_pick
   import dm_arbiter_pkg::*;
#(
   parameter bit CPU_PRIO = 1'b1
) (
   input  logic [1:0] req,
   input  logic       starve_hit,
   input  logic       rr_last,
   output logic [1:0] win
);

   // Pick the winner; an empty request vector yields an all-zero grant.
   always_comb begin
      win = 2'b00;
      if (req == 2'b01) begin
         win = port_onehot(1'b0);
      end else if (req == 2'b10) begin
         win = port_onehot(1'b1);
      end else if (req == 2'b11) begin
         if (CPU_PRIO) begin
            win = port_onehot(starve_hit);
         end else begin
            win = port_onehot(~rr_last);
         end
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// Arbiter sharing the single-port data memory between the core load/store
// port (0) and the loader/debug port (1). One access in flight at a time,
// each walking IDLE -> ACCESS -> RESP; memory drive and read return are
// registered, and requester inputs are sampled only when leaving IDLE.
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int AW         = 16,
   parameter int DW         = 32,
   parameter bit CPU_PRIO   = 1'b1,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_f,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    gnt,
   output logic          busy
);

   logic [1:0] state;
   logic [3:0] starve_cnt;
   logic       rr_last;
   logic [1:0] win;
   logic       starve_hit;
   logic       grant_now;

   assign starve_hit = (starve_cnt == 4'(STARVE_MAX));
   assign grant_now  = (state == ST_IDLE) && (win != 2'b00);

   dm_arb_pick #(
      .CPU_PRIO (CPU_PRIO)
   ) u_pick (
      .req        ({req1, req0}),
      .starve_hit (starve_hit),
      .rr_last    (rr_last),
      .win        (win)
   );

   // Fairness bookkeeping, updated only on the cycle a grant is issued.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         starve_cnt <= 4'd0;
         rr_last    <= 1'b0;
      end else if (grant_now) begin
         rr_last <= win[PORT_LDR];
         if (CPU_PRIO) begin
            if (win[PORT_LDR]) begin
               starve_cnt <= 4'd0;
            end else if (req1 && (starve_cnt < 4'(STARVE_MAX))) begin
               starve_cnt <= starve_cnt + 4'd1;
            end
         end
      end
   end

   // Access sequencer: latches the winner's request, drives memory for one
   // cycle, captures read data and pulses the owning port's ack.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state     <= ST_IDLE;
         gnt       <= 2'b00;
         busy      <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_now) begin
                  state <= ST_ACCESS;
                  gnt   <= win;
                  busy  <= 1'b1;
                  if (win[PORT_LDR]) begin
                     mem_addr  <= addr1;
                     mem_we    <= we1;
                     mem_wdata <= wdata1;
                  end else begin
                     mem_addr  <= addr0;
                     mem_we    <= we0;
                     mem_wdata <= wdata0;
                  end
               end
            end
            ST_ACCESS: begin
               state  <= ST_RESP;
               mem_we <= 1'b0;
               if (gnt[PORT_LDR]) begin
                  ack1 <= 1'b1;
                  if (!mem_we) begin
                     rdata1 <= mem_rdata;
                  end
               end else begin
                  ack0 <= 1'b1;
                  if (!mem_we) begin
                     rdata0 <= mem_rdata;
                  end
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               gnt   <= 2'b00;
               busy  <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               ack0   <= 1'b0;
               ack1   <= 1'b0;
               gnt    <= 2'b00;
               busy   <= 1'b0;
               mem_we <= 1'b0;
            end
         endcase
      end
   end

endmodule
